lc3_control: RTL and testbench
==============================

Name: lc3_control

Overview:
- Microsequencer driving every load, gate, mux-select and memory strobe of the LC-3 bus datapath.
- It is the initiator end of the datapath control interface. The datapath only reacts to these signals.
- Holds the FSM state and the NZP condition-code register.
- Executes ADD, AND, NOT, BR, JMP, LD, ST and LEA. All other opcodes halt.

Parameters:
- WORDSIZE, 16, datapath/bus width.
- STATE_BITS, 4, state register width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ir  input  WORDSIZE  instruction register contents.
- bus  input  WORDSIZE  global bus value, sampled for condition codes.
- mem_ready  input  1  memory access complete this cycle.
- ld_ir, ld_mar, ld_mdr, ld_pc, ld_reg  output  1 each  register load enables.
- gate_pc, gate_alu, gate_mdr, gate_marmux  output  1 each  bus drivers. At most one is high per cycle.
- mdr_io  output  1  0: MDR loads from memory; 1: MDR loads from bus.
- mem_en  output  1  memory access request.
- mem_rw  output  1  0 read, 1 write.
- alu_ctrl  output  2  00 ADD, 01 AND, 10 NOT, 11 PASS in1.
- pcmux  output  2  00 PC+1, 01 adder, 10 bus, 11 zero.
- addr1mux  output  1  0 PC, 1 SR1.
- addr2mux  output  2  00 zero, 01 sext(ir[5:0]), 10 sext(ir[8:0]), 11 sext(ir[10:0]).
- marmux  output  1  0 zext(ir[7:0]), 1 adder.
- dr, sr1, sr2  output  3 each  register file selects.
- nzp  output  3  current condition codes {N,Z,P}.
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset:
  - Synchronous, active-high: state <= FETCH0, nzp <= 3'b010.
  - While rst is high, all strobes, gates and loads are forced to 0 and mem_en = 0. An access in progress is abandoned.
- Default: every output not listed for a state is 0. dr = ir[11:9], sr1 = ir[8:6], sr2 = ir[2:0] unless overridden.
- All outputs are combinational from state and ir. The one exception is ld_mdr in memory-wait states, which equals mem_ready.
- States and transitions:
  - FETCH0: gate_pc, ld_mar, pcmux=00, ld_pc -> FETCH1.
  - FETCH1: mem_en, mem_rw=0, mdr_io=0, ld_mdr=mem_ready. Stay until mem_ready, then -> FETCH2. No timeout.
  - FETCH2: gate_mdr, ld_ir -> DECODE.
  - DECODE (no strobes), dispatch on ir[15:12]:
    - 0001 / 0101 / 1001 -> ALU.
    - 0000 -> BR.
    - 1100 -> JMP.
    - 0010 -> LD0.
    - 0011 -> ST0.
    - 1110 -> LEA.
    - else -> HALT.
  - ALU: gate_alu, ld_reg. alu_ctrl = 00/01/10 per opcode. nzp updated. -> FETCH0.
  - BR: if (ir[11:9] & nzp) != 0 then addr1mux=0, addr2mux=10, pcmux=01, ld_pc. Otherwise no loads. -> FETCH0.
  - JMP: addr1mux=1, addr2mux=00, pcmux=01, ld_pc. sr1=ir[8:6]. -> FETCH0.
  - LD0: addr1mux=0, addr2mux=10, marmux=1, gate_marmux, ld_mar -> LD1.
  - LD1: same as FETCH1, but -> LD2.
  - LD2: gate_mdr, ld_reg. nzp updated. -> FETCH0.
  - ST0: same as LD0 -> ST1.
  - ST1: sr1=ir[11:9], alu_ctrl=11, gate_alu, mdr_io=1, ld_mdr -> ST2.
  - ST2: mem_en, mem_rw=1. Stay until mem_ready -> FETCH0.
  - LEA: addr1mux=0, addr2mux=10, marmux=1, gate_marmux, ld_reg. nzp is NOT updated. -> FETCH0.
  - HALT: halted=1, all other outputs 0. Stays until rst.
- NZP update at the clock edge:
  - N = bus[15], Z = (bus == 0), P = !N && !Z.
  - Exactly one bit is set.
- mem_en is held continuously and mem_rw is stable until the cycle mem_ready is seen. mem_ready outside FETCH1/LD1/ST2 is ignored.
- Latency with mem_ready=1 immediately:
  - fetch: 3 cycles.
  - ALU/BR/JMP/LEA instruction: 5 cycles total.
  - LD: 7 cycles total.
  - ST: 7 cycles total.
- Undefined state encodings go to FETCH0 on the next edge.

Test Plan:
- Reset, then hold mem_ready=1 with an ADD ir=16'h1261 -> state sequence FETCH0, FETCH1, FETCH2, DECODE, ALU. In ALU: ld_reg=1, dr=1, sr1=1, alu_ctrl=00. Back in FETCH0 at cycle 5.
- Same ADD with bus=16'h8000 during ALU -> nzp=100. With bus=0 -> 010. With bus=16'h0005 -> 001.
- Hold mem_ready=0 for 4 cycles in FETCH1 -> mem_en=1, mem_rw=0 throughout and ld_mdr=0. On the cycle mem_ready=1: ld_mdr=1, then next state FETCH2.
- BR ir=16'h0805 (n only) with nzp=010 -> ld_pc=0. Same ir with nzp=100 -> ld_pc=1, pcmux=01, addr2mux=10.
- ST ir=16'h3A03 -> ST1 has sr1=5, mdr_io=1, gate_alu=1. ST2 has mem_rw=1 until mem_ready. Full instruction takes 7 cycles.
- ir=16'hF025 -> HALT, halted=1 with mem_ready toggling. Assert rst mid-ST2 -> mem_en=0 in the same cycle, FETCH0 and nzp=010 after the edge.

Source files
------------

// File: rtl/lc3_control.sv
`default_nettype none
// ============================================================================
// Module      : lc3_control
// Description : Microsequencer for the LC-3 bus datapath. Holds the FSM state
//               and the NZP condition-code register, and drives every load,
//               bus gate, mux select and memory strobe of the datapath.
//               Executes ADD, AND, NOT, BR, JMP, LD, ST and LEA; any other
//               opcode parks the sequencer in HALT until reset.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               ir, bus, mem_ready  - instruction, bus value, memory done
//               ld_*                - register load enables
//               gate_*              - bus drivers (at most one per cycle)
//               mdr_io, mem_en/rw   - MDR source, memory request/direction
//               alu_ctrl, *mux      - datapath selects
//               dr, sr1, sr2        - register file selects
//               nzp, halted         - condition codes, halt indicator
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_control #(
    parameter int WORDSIZE   = 16,
    parameter int STATE_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORDSIZE-1:0] ir,
    input  logic [WORDSIZE-1:0] bus,
    input  logic                mem_ready,
    output logic                ld_ir,
    output logic                ld_mar,
    output logic                ld_mdr,
    output logic                ld_pc,
    output logic                ld_reg,
    output logic                gate_pc,
    output logic                gate_alu,
    output logic                gate_mdr,
    output logic                gate_marmux,
    output logic                mdr_io,
    output logic                mem_en,
    output logic                mem_rw,
    output logic [1:0]          alu_ctrl,
    output logic [1:0]          pcmux,
    output logic                addr1mux,
    output logic [1:0]          addr2mux,
    output logic                marmux,
    output logic [2:0]          dr,
    output logic [2:0]          sr1,
    output logic [2:0]          sr2,
    output logic [2:0]          nzp,
    output logic                halted
);

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH0 = 0,
        S_FETCH1 = 1,
        S_FETCH2 = 2,
        S_DECODE = 3,
        S_ALU    = 4,
        S_BR     = 5,
        S_JMP    = 6,
        S_LD0    = 7,
        S_LD1    = 8,
        S_LD2    = 9,
        S_ST0    = 10,
        S_ST1    = 11,
        S_ST2    = 12,
        S_LEA    = 13,
        S_HALT   = 14
    } state_t;

    localparam logic [3:0] c_op_br  = 4'b0000;
    localparam logic [3:0] c_op_add = 4'b0001;
    localparam logic [3:0] c_op_ld  = 4'b0010;
    localparam logic [3:0] c_op_st  = 4'b0011;
    localparam logic [3:0] c_op_and = 4'b0101;
    localparam logic [3:0] c_op_not = 4'b1001;
    localparam logic [3:0] c_op_jmp = 4'b1100;
    localparam logic [3:0] c_op_lea = 4'b1110;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_nzp;
    logic       w_nzp_ld;
    logic [2:0] w_nzp_new;
    logic [3:0] w_opcode;
    logic       w_br_taken;
    logic       w_unused;

    assign w_opcode   = ir[15:12];
    assign w_br_taken = |(ir[11:9] & r_nzp);
    assign w_unused   = ^ir[5:3];
    assign nzp        = r_nzp;

    // Exactly one code bit is ever set: zero wins over sign, positive otherwise.
    always_comb begin
        if (bus == '0)
            w_nzp_new = 3'b010;
        else if (bus[WORDSIZE-1])
            w_nzp_new = 3'b100;
        else
            w_nzp_new = 3'b001;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH0;
            r_nzp   <= 3'b010;
        end else begin
            r_state <= w_next;
            if (w_nzp_ld)
                r_nzp <= w_nzp_new;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_nzp_ld    = 1'b0;
        ld_ir       = 1'b0;
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_pc       = 1'b0;
        ld_reg      = 1'b0;
        gate_pc     = 1'b0;
        gate_alu    = 1'b0;
        gate_mdr    = 1'b0;
        gate_marmux = 1'b0;
        mdr_io      = 1'b0;
        mem_en      = 1'b0;
        mem_rw      = 1'b0;
        alu_ctrl    = 2'b00;
        pcmux       = 2'b00;
        addr1mux    = 1'b0;
        addr2mux    = 2'b00;
        marmux      = 1'b0;
        dr          = ir[11:9];
        sr1         = ir[8:6];
        sr2         = ir[2:0];
        halted      = 1'b0;

        case (r_state)
            S_FETCH0: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
                w_next  = S_FETCH1;
            end
            S_FETCH1: begin
                mem_en = 1'b1;
                ld_mdr = mem_ready;
                if (mem_ready)
                    w_next = S_FETCH2;
            end
            S_FETCH2: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
                w_next   = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    c_op_add, c_op_and, c_op_not: w_next = S_ALU;
                    c_op_br:                      w_next = S_BR;
                    c_op_jmp:                     w_next = S_JMP;
                    c_op_ld:                      w_next = S_LD0;
                    c_op_st:                      w_next = S_ST0;
                    c_op_lea:                     w_next = S_LEA;
                    default:                      w_next = S_HALT;
                endcase
            end
            S_ALU: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                w_nzp_ld = 1'b1;
                case (w_opcode)
                    c_op_and: alu_ctrl = 2'b01;
                    c_op_not: alu_ctrl = 2'b10;
                    default:  alu_ctrl = 2'b00;
                endcase
                w_next = S_FETCH0;
            end
            S_BR: begin
                if (w_br_taken) begin
                    addr2mux = 2'b10;
                    pcmux    = 2'b01;
                    ld_pc    = 1'b1;
                end
                w_next = S_FETCH0;
            end
            S_JMP: begin
                addr1mux = 1'b1;
                pcmux    = 2'b01;
                ld_pc    = 1'b1;
                w_next   = S_FETCH0;
            end
            S_LD0, S_ST0: begin
                addr2mux    = 2'b10;
                marmux      = 1'b1;
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
                w_next      = (r_state == S_LD0) ? S_LD1 : S_ST1;
            end
            S_LD1: begin
                mem_en = 1'b1;
                ld_mdr = mem_ready;
                if (mem_ready)
                    w_next = S_LD2;
            end
            S_LD2: begin
                gate_mdr = 1'b1;
                ld_reg   = 1'b1;
                w_nzp_ld = 1'b1;
                w_next   = S_FETCH0;
            end
            S_ST1: begin
                // Source register for a store lives in the DR field.
                sr1      = ir[11:9];
                alu_ctrl = 2'b11;
                gate_alu = 1'b1;
                mdr_io   = 1'b1;
                ld_mdr   = 1'b1;
                w_next   = S_ST2;
            end
            S_ST2: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                if (mem_ready)
                    w_next = S_FETCH0;
            end
            S_LEA: begin
                addr2mux    = 2'b10;
                marmux      = 1'b1;
                gate_marmux = 1'b1;
                ld_reg      = 1'b1;
                w_next      = S_FETCH0;
            end
            S_HALT: begin
                halted = 1'b1;
                dr     = 3'b000;
                sr1    = 3'b000;
                sr2    = 3'b000;
            end
            default: begin
                w_next = S_FETCH0;
            end
        endcase

        // Reset abandons any access in progress: nothing may strobe the datapath.
        if (rst) begin
            ld_ir       = 1'b0;
            ld_mar      = 1'b0;
            ld_mdr      = 1'b0;
            ld_pc       = 1'b0;
            ld_reg      = 1'b0;
            gate_pc     = 1'b0;
            gate_alu    = 1'b0;
            gate_mdr    = 1'b0;
            gate_marmux = 1'b0;
            mdr_io      = 1'b0;
            mem_en      = 1'b0;
            mem_rw      = 1'b0;
            halted      = 1'b0;
            w_nzp_ld    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_control
// Description : Self-checking bench for lc3_control. Each instruction is
//               expanded from its opcode into a cycle list of expected
//               strobes (fetch, memory waits, execute), driven with random
//               bus values and memory wait counts, and checked each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [15:0] bus;
    logic        mem_ready;
    logic        ld_ir, ld_mar, ld_mdr, ld_pc, ld_reg;
    logic        gate_pc, gate_alu, gate_mdr, gate_marmux;
    logic        mdr_io, mem_en, mem_rw;
    logic [1:0]  alu_ctrl, pcmux, addr2mux;
    logic        addr1mux, marmux;
    logic [2:0]  dr, sr1, sr2, nzp;
    logic        halted;

    always #5 clk = ~clk;

    lc3_control #(.WORDSIZE(16), .STATE_BITS(4)) dut (
        .clk(clk), .rst(rst), .ir(ir), .bus(bus), .mem_ready(mem_ready),
        .ld_ir(ld_ir), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_pc(ld_pc),
        .ld_reg(ld_reg), .gate_pc(gate_pc), .gate_alu(gate_alu),
        .gate_mdr(gate_mdr), .gate_marmux(gate_marmux), .mdr_io(mdr_io),
        .mem_en(mem_en), .mem_rw(mem_rw), .alu_ctrl(alu_ctrl), .pcmux(pcmux),
        .addr1mux(addr1mux), .addr2mux(addr2mux), .marmux(marmux),
        .dr(dr), .sr1(sr1), .sr2(sr2), .nzp(nzp), .halted(halted)
    );

    int passes = 0;
    int checks = 0;
    logic [2:0] m_nzp;

    // Expected per-cycle behaviour of the instruction being run.
    bit q_men[$], q_rw[$], q_mdr[$], q_pc[$], q_reg[$], q_rdy[$], q_upd[$];
    int q_tag[$];

    localparam int T_NONE = 0, T_ALU = 1, T_BRT = 2, T_JMP = 3, T_STD = 4,
                   T_LEA = 5, T_ADR = 6, T_LDW = 7;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] nzp_of(input logic [15:0] b);
        if (b == 16'h0)     return 3'b010;
        else if ($signed(b) < 0) return 3'b100;
        else                return 3'b001;
    endfunction

    function automatic logic [15:0] rand_bus();
        if ($urandom_range(0, 3) == 0) return 16'h0000;
        return 16'($urandom);
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input bit men, input bit rw, input bit mdr, input bit pc,
                        input bit rg, input bit rdy, input bit upd, input int tag);
        q_men.push_back(men); q_rw.push_back(rw); q_mdr.push_back(mdr);
        q_pc.push_back(pc); q_reg.push_back(rg); q_rdy.push_back(rdy);
        q_upd.push_back(upd); q_tag.push_back(tag);
    endtask

    // A memory read phase: w wait cycles, then the cycle the data arrives.
    task automatic push_read(input int w);
        for (int k = 0; k < w; k++) push(1, 0, 0, 0, 0, 0, 0, T_NONE);
        push(1, 0, 1, 0, 0, 1, 0, T_NONE);
    endtask

    // Runs one instruction from FETCH0 to the next FETCH0. fb[16] forces
    // the bus value fb[15:0] on the condition-code update cycle.
    task automatic run_instr(input logic [15:0] iv, input int w0, input int w1,
                             input logic [16:0] fb);
        logic [3:0] op;
        bit taken;
        int n;
        op = iv[15:12];
        q_men.delete(); q_rw.delete(); q_mdr.delete(); q_pc.delete();
        q_reg.delete(); q_rdy.delete(); q_upd.delete(); q_tag.delete();

        push(0, 0, 0, 1, 0, rbit(), 0, T_NONE);     // PC -> MAR, PC+1
        push_read(w0);                             // instruction read
        push(0, 0, 0, 0, 0, rbit(), 0, T_NONE);     // MDR -> IR
        push(0, 0, 0, 0, 0, rbit(), 0, T_NONE);     // decode
        case (op)
            4'h1, 4'h5, 4'h9: push(0, 0, 0, 0, 1, rbit(), 1, T_ALU);
            4'h0: begin
                taken = |(iv[11:9] & m_nzp);
                push(0, 0, 0, taken, 0, rbit(), 0, taken ? T_BRT : T_NONE);
            end
            4'hC: push(0, 0, 0, 1, 0, rbit(), 0, T_JMP);
            4'hE: push(0, 0, 0, 0, 1, rbit(), 0, T_LEA);
            4'h2: begin
                push(0, 0, 0, 0, 0, rbit(), 0, T_ADR);
                push_read(w1);
                push(0, 0, 0, 0, 1, rbit(), 1, T_LDW);
            end
            4'h3: begin
                push(0, 0, 0, 0, 0, rbit(), 0, T_ADR);
                push(0, 0, 1, 0, 0, rbit(), 0, T_STD);
                for (int k = 0; k < w1; k++) push(1, 1, 0, 0, 0, 0, 0, T_NONE);
                push(1, 1, 0, 0, 0, 1, 0, T_NONE);
            end
            default: ;
        endcase

        ir = iv;
        n = q_men.size();
        for (int i = 0; i < n; i++) begin
            mem_ready = q_rdy[i];
            bus = (q_upd[i] && fb[16]) ? fb[15:0] : rand_bus();
            #1;
            chk("mem_en", 16'(mem_en), 16'(q_men[i]));
            chk("mem_rw", 16'(mem_rw), 16'(q_rw[i]));
            chk("ld_mdr", 16'(ld_mdr), 16'(q_mdr[i]));
            chk("ld_pc", 16'(ld_pc), 16'(q_pc[i]));
            chk("ld_reg", 16'(ld_reg), 16'(q_reg[i]));
            chk("gate_onehot0",
                16'($countones({gate_pc, gate_alu, gate_mdr, gate_marmux}) <= 1), 16'd1);
            case (q_tag[i])
                T_ALU: begin
                    chk("alu_ctrl", 16'(alu_ctrl),
                        (op == 4'h1) ? 16'd0 : (op == 4'h5) ? 16'd1 : 16'd2);
                    chk("alu_gate", 16'(gate_alu), 16'd1);
                    chk("alu_dr", 16'(dr), 16'(iv[11:9]));
                    chk("alu_sr1", 16'(sr1), 16'(iv[8:6]));
                end
                T_BRT: chk("br_sel", {12'd0, pcmux, addr2mux}, 16'b0110);
                T_JMP: begin
                    chk("jmp_sel", {12'd0, pcmux, addr1mux, addr2mux[0]}, 16'b0110);
                    chk("jmp_sr1", 16'(sr1), 16'(iv[8:6]));
                end
                T_STD: begin
                    chk("st_sr1", 16'(sr1), 16'(iv[11:9]));
                    chk("st_drive", {12'd0, alu_ctrl, gate_alu, mdr_io}, 16'b1111);
                end
                T_LEA: chk("lea_sel", {12'd0, gate_marmux, marmux, addr2mux}, 16'b1110);
                T_ADR: chk("addr_sel", {11'd0, ld_mar, gate_marmux, marmux, addr2mux}, 16'b11110);
                T_LDW: begin
                    chk("ld_gate", 16'(gate_mdr), 16'd1);
                    chk("ld_dr", 16'(dr), 16'(iv[11:9]));
                end
                default: ;
            endcase
            if (q_upd[i]) m_nzp = nzp_of(bus);
            @(posedge clk);
            #1;
        end
        chk("nzp", 16'(nzp), 16'(m_nzp));
        chk("back_to_fetch", {13'd0, gate_pc, ld_mar, ld_pc}, 16'b111);
    endtask

    task automatic step(input bit rdy);
        mem_ready = rdy;
        bus = rand_bus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ops [8];
        ops = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h2, 4'h3, 4'hE};

        rst = 1'b1; ir = 16'h0; bus = 16'h0; mem_ready = 1'b1;
        m_nzp = 3'b010;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_en", 16'(mem_en), 16'd0);
        chk("rst_gate_pc", 16'(gate_pc), 16'd0);
        chk("rst_ld_pc", 16'(ld_pc), 16'd0);
        rst = 1'b0;
        #1;
        chk("rst_nzp", 16'(nzp), 16'b010);
        chk("rst_fetch0", {13'd0, gate_pc, ld_mar, ld_pc}, 16'b111);

        // ADD with each sign class of result, then a slow fetch.
        run_instr(16'h1261, 0, 0, {1'b1, 16'h8000});
        run_instr(16'h1261, 0, 0, {1'b1, 16'h0000});
        run_instr(16'h1261, 0, 0, {1'b1, 16'h0005});
        run_instr(16'h1261, 4, 0, {1'b1, 16'h0000});
        // BRn with Z set (not taken), then with N set (taken).
        run_instr(16'h0805, 0, 0, 17'h0);
        run_instr(16'h1261, 0, 0, {1'b1, 16'hFFFF});
        run_instr(16'h0805, 0, 0, 17'h0);
        // Store, load, jump, LEA, AND, NOT.
        run_instr(16'h3A03, 0, 0, 17'h0);
        run_instr(16'h3A03, 1, 3, 17'h0);
        run_instr(16'h2C10, 2, 2, {1'b1, 16'h7FFF});
        run_instr(16'hC1C0, 0, 0, 17'h0);
        run_instr(16'hE5FF, 0, 0, 17'h0);
        run_instr(16'h5482, 0, 0, {1'b1, 16'h0000});
        run_instr(16'h96BF, 0, 0, {1'b1, 16'h8001});

        for (int t = 0; t < 60; t++) begin
            logic [15:0] iv;
            iv = {ops[$urandom_range(0, 7)], 12'($urandom)};
            run_instr(iv, $urandom_range(0, 3), $urandom_range(0, 3), 17'h0);
        end

        // Unimplemented opcode halts and ignores memory handshakes.
        ir = 16'hF025;
        for (int k = 0; k < 4; k++) step(1'b1);
        for (int k = 0; k < 6; k++) begin
            mem_ready = bit'(k[0]);
            #1;
            chk("halted", 16'(halted), 16'd1);
            chk("halt_quiet", {12'd0, mem_en, ld_pc, ld_mdr, ld_mar}, 16'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_nzp = 3'b010;
        #1;
        chk("halt_rst_fetch0", {13'd0, gate_pc, ld_mar, ld_pc}, 16'b111);

        // Reset while a store is waiting on memory.
        run_instr(16'h1261, 0, 0, {1'b1, 16'h8000});
        ir = 16'h3A03;
        for (int k = 0; k < 6; k++) step(1'b1);   // FETCH0..ST1
        mem_ready = 1'b0;
        #1;
        chk("st2_mem_en", 16'(mem_en), 16'd1);
        chk("st2_mem_rw", 16'(mem_rw), 16'd1);
        rst = 1'b1;
        #1;
        chk("st2_rst_mem_en", 16'(mem_en), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("st2_rst_nzp", 16'(nzp), 16'b010);
        chk("st2_rst_fetch0", {13'd0, gate_pc, ld_mar, ld_pc}, 16'b111);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
